// File: rtl/contador_pkg.sv
// Shared FSM state encoding and default sizes for the contador timebase.
package contador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 28;
    localparam int DEF_UNIT_W = 4;

endpackage

// File: rtl/contador_presc.sv
// Free-running prescaler: counts 0..period-1, flags the wrap edge and
// registers a one-cycle tick after it.
module contador_presc
    import contador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hold,
    input  logic             clr,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             tick
);

    logic [WIDTH:0] q_inc;

    assign q_inc = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};

    // q+1 >= period covers period 0/1 (wrap every edge) and a period lowered
    // below the current count (wrap at once instead of running to 2^WIDTH).
    assign wrap = en && !hold && (q_inc >= {1'b0, period});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (clr || wrap)
                q <= '0;
            else if (en && !hold)
                q <= q_inc[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/contador_timebase.sv
// Morse timebase: prescaler plus IDLE/RUN/DONE duration FSM counting units.
// Define CONTADOR_PAUSE_EN to add the PAUSE input (freezes timing while in RUN).
module contador_timebase
    import contador_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int UNIT_W = DEF_UNIT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [WIDTH-1:0]  PERIOD,
    input  logic              START,
    input  logic [UNIT_W-1:0] UNITS,
`ifdef CONTADOR_PAUSE_EN
    input  logic              PAUSE,
`endif
    output logic [WIDTH-1:0]  Q,
    output logic              TICK,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [UNIT_W-1:0] UNIT_ONE = {{(UNIT_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [UNIT_W-1:0] units_left, units_nxt;
    logic              wrap, hold, clr;

`ifdef CONTADOR_PAUSE_EN
    assign hold = PAUSE && (state == ST_RUN);
`else
    assign hold = 1'b0;
`endif

    // Q restarts from 0 so the first unit of a duration is a full period.
    assign clr = START && (state == ST_IDLE) && (UNITS != '0);

    contador_presc #(.WIDTH(WIDTH)) u_presc (
        .clk    (CLK),
        .rst_n  (RST_N),
        .en     (EN),
        .hold   (hold),
        .clr    (clr),
        .period (PERIOD),
        .q      (Q),
        .wrap   (wrap),
        .tick   (TICK)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            units_left <= '0;
        end else begin
            state      <= state_nxt;
            units_left <= units_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        units_nxt = units_left;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    if (UNITS == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RUN;
                        units_nxt = UNITS;
                    end
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    units_nxt = units_left - UNIT_ONE;
                    if (units_left == UNIT_ONE)
                        state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign BUSY = (state == ST_RUN);
    assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_contador_timebase.sv
// Self-checking bench for contador_timebase: directed scenarios plus a
// randomized run against a behavioural duration/prescaler model.
module tb_contador_timebase;

    localparam int W  = 28;
    localparam int UW = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          EN = 1'b0;
    logic [W-1:0]  PERIOD = '0;
    logic          START = 1'b0;
    logic [UW-1:0] UNITS = '0;
    logic          PAUSE = 1'b0;
    logic [W-1:0]  Q;
    logic          TICK, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    // Model: prescaler count, units still to time, and the two visible flags.
    int m_q = 0, m_left = 0;
    bit m_tick = 0, m_busy = 0, m_done = 0;

    always #5 CLK = ~CLK;

    contador_timebase #(.WIDTH(W), .UNIT_W(UW)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .EN     (EN),
        .PERIOD (PERIOD),
        .START  (START),
        .UNITS  (UNITS),
`ifdef CONTADOR_PAUSE_EN
        .PAUSE  (PAUSE),
`endif
        .Q      (Q),
        .TICK   (TICK),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    // Advance one rising edge, update the model from the inputs seen there,
    // and return 1 time unit later so outputs can be sampled.
    task automatic step();
        bit wrap, accept, hold;
        @(posedge CLK);
        if (!RST_N) begin
            m_q = 0; m_left = 0; m_tick = 0; m_busy = 0; m_done = 0;
        end else begin
            hold   = PAUSE && m_busy;
            wrap   = EN && !hold && (int'(PERIOD) <= 1 || m_q + 1 >= int'(PERIOD));
            accept = START && !m_busy && !m_done;
            m_tick = wrap;
            if ((accept && UNITS != 0) || wrap) m_q = 0;
            else if (EN && !hold)               m_q = m_q + 1;
            if (m_done) begin
                m_done = 0;
            end else if (accept) begin
                if (UNITS == 0) m_done = 1;
                else begin m_busy = 1; m_left = int'(UNITS); end
            end else if (m_busy && wrap) begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_busy = 0; m_done = 1; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; EN = 1'b1; START = 1'b1; UNITS = 4'd3; PERIOD = 28'd4;
        step(); step();
        checks++; if (Q !== '0)     begin errors++; $display("FAIL reset_q got %0d exp 0", Q); end
        checks++; if (TICK !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b exp 0", TICK); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", DONE); end
        START = 1'b0;
    endtask

    task automatic test_free_run();
        RST_N = 1'b1; EN = 1'b1; PERIOD = 28'd4;
        for (int j = 1; j <= 12; j++) begin
            step();
            checks++;
            if (Q !== W'(j % 4) || TICK !== (j % 4 == 0)) begin
                errors++;
                $display("FAIL free_run j=%0d got q=%0d tick=%0b exp q=%0d tick=%0b",
                         j, Q, TICK, j % 4, (j % 4 == 0));
            end
        end
    endtask

    task automatic test_duration();
        PERIOD = 28'd5; UNITS = 4'd3; START = 1'b1;
        step();
        START = 1'b0;
        checks++;
        if (Q !== '0 || BUSY !== 1'b1 || DONE !== 1'b0) begin
            errors++; $display("FAIL dur_accept got q=%0d busy=%0b done=%0b exp 0/1/0", Q, BUSY, DONE);
        end
        for (int j = 1; j <= 16; j++) begin
            // A second request mid-RUN must not restart or shorten the duration.
            START = (j == 7); UNITS = (j == 7) ? 4'd1 : 4'd3;
            step();
            checks++;
            if (BUSY !== (j < 15) || DONE !== (j == 15) || TICK !== (j % 5 == 0)) begin
                errors++;
                $display("FAIL duration j=%0d got busy=%0b done=%0b tick=%0b exp %0b/%0b/%0b",
                         j, BUSY, DONE, TICK, (j < 15), (j == 15), (j % 5 == 0));
            end
        end
        START = 1'b0;
    endtask

    task automatic test_zero_units();
        int exp_q;
        UNITS = 4'd0; START = 1'b1;
        exp_q = (m_q + 1 >= 5) ? 0 : m_q + 1;
        step();
        START = 1'b0;
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || int'(Q) !== exp_q) begin
            errors++; $display("FAIL zero_units got done=%0b busy=%0b q=%0d exp 1/0/%0d", DONE, BUSY, Q, exp_q);
        end
        step();
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL zero_units_after got done=%0b busy=%0b exp 0/0", DONE, BUSY);
        end
    endtask

    task automatic test_period_drop();
        bit seen = 0;
        PERIOD = 28'd10;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (Q == 28'd8) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL period_drop_reach got no q=8 exp q=8 within 20 cycles"); end
        PERIOD = 28'd4;
        step();
        checks++;
        if (Q !== '0 || TICK !== 1'b1) begin
            errors++; $display("FAIL period_drop got q=%0d tick=%0b exp q=0 tick=1", Q, TICK);
        end
    endtask

    task automatic test_en_stretch();
        PERIOD = 28'd3; UNITS = 4'd2; START = 1'b1; EN = 1'b1;
        step();
        START = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            EN = !(j >= 3 && j <= 9);
            step();
            checks++;
            if (DONE !== (j == 13) || BUSY !== (j < 13) || (!EN && TICK !== 1'b0)) begin
                errors++;
                $display("FAIL en_stretch j=%0d got done=%0b busy=%0b tick=%0b exp done=%0b busy=%0b",
                         j, DONE, BUSY, TICK, (j == 13), (j < 13));
            end
        end
        EN = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        PERIOD = 28'd4; UNITS = 4'd5; START = 1'b1;
        step();
        START = 1'b0;
        for (int j = 0; j < 6; j++) step();
        RST_N = 1'b0;
        step();
        checks++;
        if (Q !== '0 || TICK !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++; $display("FAIL mid_run_reset got q=%0d t=%0b b=%0b d=%0b exp all 0", Q, TICK, BUSY, DONE);
        end
        RST_N = 1'b1;
        for (int j = 0; j < 25; j++) begin
            step();
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || int'(Q) !== m_q) begin
                errors++; $display("FAIL after_abort j=%0d got done=%0b busy=%0b q=%0d exp 0/0/%0d",
                                   j, DONE, BUSY, Q, m_q);
            end
        end
    endtask

`ifdef CONTADOR_PAUSE_EN
    task automatic test_pause();
        PERIOD = 28'd4; UNITS = 4'd2; START = 1'b1; EN = 1'b1;
        step();
        START = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            PAUSE = (j >= 3 && j <= 5);
            step();
            checks++;
            if (DONE !== (j == 11) || BUSY !== (j < 11) || (PAUSE && TICK !== 1'b0)) begin
                errors++;
                $display("FAIL pause j=%0d got done=%0b busy=%0b tick=%0b exp done=%0b busy=%0b",
                         j, DONE, BUSY, TICK, (j == 11), (j < 11));
            end
        end
        PAUSE = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            RST_N = ($urandom_range(0, 199) != 0);
            EN    = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 39) == 0) PERIOD = W'($urandom_range(0, 7));
            START = ($urandom_range(0, 9) == 0);
            UNITS = UW'($urandom_range(0, 3));
`ifdef CONTADOR_PAUSE_EN
            PAUSE = ($urandom_range(0, 7) == 0);
`endif
            step();
            checks++;
            if (int'(Q) !== m_q || TICK !== m_tick || BUSY !== m_busy || DONE !== m_done) begin
                errors++;
                $display("FAIL random i=%0d got q=%0d t=%0b b=%0b d=%0b exp q=%0d t=%0b b=%0b d=%0b",
                         i, Q, TICK, BUSY, DONE, m_q, m_tick, m_busy, m_done);
            end
        end
        RST_N = 1'b1; START = 1'b0; PAUSE = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_duration();
        test_zero_units();
        test_period_drop();
        test_en_stretch();
        test_reset_mid_run();
`ifdef CONTADOR_PAUSE_EN
        test_pause();
`endif
        PERIOD = 28'd3;
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
